// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the register file and its scoreboard.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 6;

  typedef logic [DATA_WIDTH-1:0] reg_data_t;
  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

  // Hard-wired zero register.
  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set by issue, cleared by write-back, newer issue wins.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned AddrWidth = ADDR_WIDTH,
  parameter int unsigned NumRegs   = 1 << AddrWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_en_i,
  input  logic [AddrWidth-1:0] issue_addr_i,
  input  logic                 wr_en_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  output logic [NumRegs-1:0]   busy_o
);

  logic [NumRegs-1:0] busy_q, busy_d;

  // Next busy vector: clear on write-back first so a same-edge issue re-sets it.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i) begin
      busy_d[wr_addr_i] = 1'b0;
    end
    if (issue_en_i) begin
      busy_d[issue_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy state register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read, one-write register file with busy scoreboard and commit counter.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_sb #(
  parameter int unsigned DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  output logic                  rs_busy,
  output logic                  rt_busy,
  output logic [15:0]           wr_count
);

  import cpu_pkg::*;

  localparam int unsigned NumRegs = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] Zero = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic [15:0]           count_q;
  logic [NumRegs-1:0]    busy;
  logic                  wr_commit;

  assign wr_commit = wr_en && (wr_addr != Zero);

  reg_scoreboard #(
    .AddrWidth (ADDR_WIDTH),
    .NumRegs   (NumRegs)
  ) u_scoreboard (
    .clk_i        (clock),
    .rst_i        (reset),
    .issue_en_i   (issue_en),
    .issue_addr_i (issue_addr),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .busy_o       (busy)
  );

  // Register storage; entry 0 is never written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_commit) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Committed-write counter, wraps naturally at 16 bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (wr_commit) begin
      count_q <= count_q + 16'd1;
    end
  end

  // Combinational read ports, with optional same-cycle write forwarding.
  always_comb begin
    rs_data = (rs_addr == Zero) ? '0 : regs_q[rs_addr];
    rt_data = (rt_addr == Zero) ? '0 : regs_q[rt_addr];
    rs_busy = busy[rs_addr];
    rt_busy = busy[rt_addr];
`ifdef REG_FILE_BYPASS_EN
    // Gate with reset so forwarded data cannot leak out while the file is held clear.
    if (wr_commit && !reset && (rs_addr == wr_addr)) begin
      rs_data = wr_data;
      rs_busy = 1'b0;
    end
    if (wr_commit && !reset && (rt_addr == wr_addr)) begin
      rt_data = wr_data;
      rt_busy = 1'b0;
    end
`endif
  end

  assign wr_count = count_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard-driven bench for reg_file_sb; build with REG_FILE_BYPASS_EN to cover forwarding.
module tb_reg_file_sb;

  logic        clock, reset;
  logic        wr_en, issue_en;
  logic [5:0]  wr_addr, issue_addr, rs_addr, rt_addr;
  logic [31:0] wr_data, rs_data, rt_data;
  logic        rs_busy, rt_busy;
  logic [15:0] wr_count;

  reg_file_sb dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .rs_busy    (rs_busy),
    .rt_busy    (rt_busy),
    .wr_count   (wr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic        rs_b;
    logic        rt_b;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs [64];
  logic [63:0] m_busy;
  logic [15:0] m_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_regs[i] = '0;
    m_busy = '0;
    m_cnt  = '0;
  endtask

  function automatic logic [31:0] model_data(input logic [5:0] a, input logic we,
                                             input logic [5:0] wa, input logic [31:0] wd);
    logic [31:0] d;
    d = (a == 6'd0) ? 32'd0 : m_regs[a];
`ifdef REG_FILE_BYPASS_EN
    if (we && wa != 6'd0 && a == wa) d = wd;
`endif
    return d;
  endfunction

  function automatic logic model_busy(input logic [5:0] a, input logic we, input logic [5:0] wa);
    logic b;
    b = (a == 6'd0) ? 1'b0 : m_busy[a];
`ifdef REG_FILE_BYPASS_EN
    if (we && wa != 6'd0 && a == wa) b = 1'b0;
`endif
    return b;
  endfunction

  // One cycle: drive, push expectation, compare at negedge, advance model at posedge.
  task automatic step(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                      input logic ie, input logic [5:0] ia,
                      input logic [5:0] ra, input logic [5:0] rb);
    exp_t e, g;
    wr_en = we; wr_addr = wa; wr_data = wd;
    issue_en = ie; issue_addr = ia; rs_addr = ra; rt_addr = rb;
    e.rs_d = model_data(ra, we, wa, wd);
    e.rt_d = model_data(rb, we, wa, wd);
    e.rs_b = model_busy(ra, we, wa);
    e.rt_b = model_busy(rb, we, wa);
    e.cnt  = m_cnt;
    exp_q.push_back(e);
    @(negedge clock);
    g = exp_q.pop_front();
    check("rs_data", rs_data, g.rs_d);
    check("rt_data", rt_data, g.rt_d);
    check("rs_busy", {31'd0, rs_busy}, {31'd0, g.rs_b});
    check("rt_busy", {31'd0, rt_busy}, {31'd0, g.rt_b});
    check("wr_count", {16'd0, wr_count}, {16'd0, g.cnt});
    @(posedge clock);
    if (we && wa != 6'd0) begin
      m_regs[wa] = wd;
      m_cnt = m_cnt + 16'd1;
    end
    if (we) m_busy[wa] = 1'b0;
    if (ie) m_busy[ia] = 1'b1;
    m_busy[0] = 1'b0;
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; issue_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #1;
    model_clear();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    issue_en = 0; issue_addr = 0; rs_addr = 6'd5; rt_addr = 6'd9;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    // Outputs held at zero during reset.
    check("rst_rs_data", rs_data, 32'd0);
    check("rst_count", {16'd0, wr_count}, 32'd0);
    reset = 1'b0;

    // Every address reads zero and idle after reset.
    for (int i = 0; i < 64; i++) step(0, 0, 0, 0, 0, 6'(i), 6'(63 - i));

    // Basic write then read.
    step(1, 6'd5, 32'hDEADBEEF, 0, 0, 6'd5, 6'd5);
    step(0, 0, 0, 0, 0, 6'd5, 6'd4);
    check("dead_rs", rs_data, 32'hDEADBEEF);
    check("dead_cnt", {16'd0, wr_count}, 32'd1);

    // Issue reg 7, write it two cycles later.
    step(0, 0, 0, 1, 6'd7, 6'd0, 6'd7);
    check("busy7_a", {31'd0, rt_busy}, 32'd1);
    step(0, 0, 0, 0, 0, 6'd0, 6'd7);
    step(1, 6'd7, 32'h77, 0, 0, 6'd0, 6'd7);
    step(0, 0, 0, 0, 0, 6'd0, 6'd7);
    check("busy7_clr", {31'd0, rt_busy}, 32'd0);

    // Same-edge issue and write: newer producer keeps it busy.
    step(1, 6'd9, 32'h99, 1, 6'd9, 6'd9, 6'd9);
    step(0, 0, 0, 0, 0, 6'd9, 6'd9);
    check("busy9", {31'd0, rs_busy}, 32'd1);
    // Write to an idle register leaves it idle.
    step(1, 6'd12, 32'hC, 0, 0, 6'd12, 6'd9);
    // Register 0 ignores writes and issues.
    step(1, 6'd0, 32'h1, 1, 6'd0, 6'd0, 6'd0);
    step(0, 0, 0, 0, 0, 6'd0, 6'd0);
    check("r0_data", rs_data, 32'd0);
    check("r0_cnt", {16'd0, wr_count}, {16'd0, m_cnt});

    // Same-cycle read of a register being written.
    step(1, 6'd3, 32'h11, 0, 0, 6'd3, 6'd3);
    step(1, 6'd3, 32'hA5A5A5A5, 0, 0, 6'd3, 6'd3);
    step(0, 0, 0, 0, 0, 6'd3, 6'd5);

    // A few random cycles against the model.
    for (int i = 0; i < 200; i++)
      step(1'($urandom), 6'($urandom), $urandom, 1'($urandom), 6'($urandom),
           6'($urandom), 6'($urandom));

    // Counter wraps back to zero after 65536 writes.
    do_reset();
    for (int i = 0; i < 65536; i++) begin
      if (i % 4096 == 0) step(1, 6'd1, 32'(i), 0, 0, 6'd1, 6'd2);
      else begin
        wr_en = 1'b1; wr_addr = 6'd1; wr_data = 32'(i);
        @(posedge clock);
        m_regs[1] = 32'(i);
        m_cnt = m_cnt + 16'd1;
        #1;
      end
    end
    idle();
    #1;
    check("wrap_cnt", {16'd0, wr_count}, 32'd0);

    // Reset mid-stream clears everything at once.
    step(0, 0, 0, 1, 6'd2, 6'd1, 6'd2);
    step(1, 6'd1, 32'h1234, 0, 0, 6'd1, 6'd2);
    wr_en = 1'b1; wr_addr = 6'd1; wr_data = 32'hBAD;
    #2;
    reset = 1'b1;
    #1;
    check("arst_rs", rs_data, 32'd0);
    check("arst_busy", {31'd0, rt_busy}, 32'd0);
    check("arst_cnt", {16'd0, wr_count}, 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    model_clear();
    step(0, 0, 0, 0, 0, 6'd1, 6'd2);
    check("deassert_nowr", rs_data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
